pipeline_run_ctrl: RTL and testbench

Run-control and performance-accounting controller for `Pipeline_top`. It sequences the core from reset through execution to halt and holds the core in reset and stall around that run. It stops the core on a cycle budget, a retired-instruction budget or an external halt request, and supports single-step after halt. It also owns the `cycle_count` and `instr_retired` counters, so benches and software read CPI from one authoritative place.

---
 rtl/pipeline_run_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_run_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_ctrl.sv
// Run-control sequencer for Pipeline_top: reset hold, run, halt, single-step, and the
// saturating cycle/retire counters. Every output is a flop loaded from next-state values.
module pipeline_run_ctrl #(
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic [CNT_W-1:0] retire_limit,
  input  logic             retire_valid,
  output logic             core_rst_n,
  output logic             core_stall,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_retired
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);

  localparam logic [1:0] CAUSE_STEP   = 2'b00;
  localparam logic [1:0] CAUSE_CYCLES = 2'b01;
  localparam logic [1:0] CAUSE_RETIRE = 2'b10;
  localparam logic [1:0] CAUSE_HALT   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_CORE,
    S_RUN,
    S_STEP,
    S_HALTED
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cyc_lim, ret_lim, cyc_lim_nxt, ret_lim_nxt;
  logic [CNT_W-1:0] cyc_nxt, ret_nxt, cyc_inc, ret_inc;
  logic [RC_W-1:0]  rst_cnt, rst_cnt_nxt;
  logic [1:0]       cause_nxt;
  logic             done_nxt;
  logic             hit_ret, hit_cyc;

  // Saturating increments; limit hits are judged on the post-increment values.
  always_comb begin
    cyc_inc = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
    ret_inc = (retire_valid && !(&instr_retired)) ? instr_retired + CNT_W'(1) : instr_retired;
    hit_ret = (ret_lim != '0) && (ret_inc == ret_lim);
    hit_cyc = (cyc_lim != '0) && (cyc_inc == cyc_lim);
  end

  always_comb begin
    state_nxt   = state;
    cyc_nxt     = cycle_count;
    ret_nxt     = instr_retired;
    cyc_lim_nxt = cyc_lim;
    ret_lim_nxt = ret_lim;
    rst_cnt_nxt = rst_cnt;
    cause_nxt   = done_cause;
    done_nxt    = 1'b0;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_nxt   = S_RESET_CORE;
          cyc_nxt     = '0;
          ret_nxt     = '0;
          cause_nxt   = CAUSE_STEP;
          cyc_lim_nxt = cycle_limit;
          ret_lim_nxt = retire_limit;
          rst_cnt_nxt = RC_W'(RST_CYCLES);
        end else if (state == S_HALTED && step) begin
          state_nxt = S_STEP;
        end
      end
      S_RESET_CORE: begin
        if (rst_cnt <= RC_W'(1)) begin
          state_nxt = S_RUN;
        end else begin
          rst_cnt_nxt = rst_cnt - RC_W'(1);
        end
      end
      S_RUN: begin
        cyc_nxt = cyc_inc;
        ret_nxt = ret_inc;
        if (hit_ret) begin
          state_nxt = S_HALTED;
          cause_nxt = CAUSE_RETIRE;
          done_nxt  = 1'b1;
        end else if (hit_cyc) begin
          state_nxt = S_HALTED;
          cause_nxt = CAUSE_CYCLES;
          done_nxt  = 1'b1;
        end else if (halt_req) begin
          state_nxt = S_HALTED;
          cause_nxt = CAUSE_HALT;
          done_nxt  = 1'b1;
        end
      end
      S_STEP: begin
        cyc_nxt = cyc_inc;
        ret_nxt = ret_inc;
        // A retirement completes the step even if halt_req arrives alongside it.
        if (retire_valid) begin
          state_nxt = S_HALTED;
          cause_nxt = CAUSE_STEP;
          done_nxt  = 1'b1;
        end else if (halt_req) begin
          state_nxt = S_HALTED;
          cause_nxt = CAUSE_HALT;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cycle_count   <= '0;
      instr_retired <= '0;
      cyc_lim       <= '0;
      ret_lim       <= '0;
      rst_cnt       <= '0;
      done_cause    <= CAUSE_STEP;
      done          <= 1'b0;
      core_rst_n    <= 1'b0;
      core_stall    <= 1'b1;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cycle_count   <= cyc_nxt;
      instr_retired <= ret_nxt;
      cyc_lim       <= cyc_lim_nxt;
      ret_lim       <= ret_lim_nxt;
      rst_cnt       <= rst_cnt_nxt;
      done_cause    <= cause_nxt;
      done          <= done_nxt;
      core_rst_n    <= !(state_nxt == S_IDLE || state_nxt == S_RESET_CORE);
      core_stall    <= !(state_nxt == S_RUN || state_nxt == S_STEP);
      busy          <= (state_nxt == S_RESET_CORE) || (state_nxt == S_RUN) || (state_nxt == S_STEP);
    end
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed scenarios plus random traffic, checked every
// cycle against a phase/counter model, with literal expectations at scenario ends.
module tb_pipeline_run_ctrl;
  localparam int W    = 8;
  localparam int RC   = 2;
  localparam int MAXV = (1 << W) - 1;
  localparam int P_IDLE = 0, P_RST = 1, P_RUN = 2, P_STEP = 3, P_HALT = 4;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, step = 1'b0, halt_req = 1'b0;
  logic [W-1:0] cycle_limit = '0, retire_limit = '0;
  logic         retire_valid;
  logic         core_rst_n, core_stall, busy, done;
  logic [1:0]   done_cause;
  logic [W-1:0] cycle_count, instr_retired;

  int   rv_mode = 0;
  logic rv_man = 1'b0, rv_gen = 1'b0;
  logic chk_en = 1'b0;
  int   checks = 0, errors = 0;
  int   lows;

  always #5 clk = ~clk;

  assign retire_valid = (rv_mode == 0) ? rv_man : rv_gen;

  always @(posedge clk) begin
    #1;
    case (rv_mode)
      1:       rv_gen <= 1'b1;
      2:       rv_gen <= ~rv_gen;
      3:       rv_gen <= 1'($urandom_range(0, 1));
      default: rv_gen <= 1'b0;
    endcase
  end

  pipeline_run_ctrl #(.CNT_W(W), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .halt_req(halt_req),
    .cycle_limit(cycle_limit), .retire_limit(retire_limit), .retire_valid(retire_valid),
    .core_rst_n(core_rst_n), .core_stall(core_stall), .busy(busy), .done(done),
    .done_cause(done_cause), .cycle_count(cycle_count), .instr_retired(instr_retired)
  );

  // Model: which phase the run is in, cycles left in reset, counts, limits, cause.
  typedef struct {
    int ph; int rleft; int cyc; int ret; int cl; int rl; int cause; int dn;
  } mdl_t;
  mdl_t m = '{P_IDLE, 0, 0, 0, 0, 0, 0, 0};

  function automatic mdl_t nxt(mdl_t c, bit r, bit st, bit sp, bit hr, bit rv, int cl, int rl);
    mdl_t n = c;
    int   rvi = rv ? 1 : 0;
    n.dn = 0;
    if (r) begin
      n = '{P_IDLE, 0, 0, 0, 0, 0, 0, 0};
      return n;
    end
    if ((c.ph == P_IDLE || c.ph == P_HALT) && st) begin
      n = '{P_RST, RC, 0, 0, cl, rl, 0, 0};
      return n;
    end
    if (c.ph == P_RST) begin
      n.rleft = c.rleft - 1;
      if (n.rleft == 0) n.ph = P_RUN;
    end else if (c.ph == P_HALT) begin
      if (sp) n.ph = P_STEP;
    end else if (c.ph == P_RUN || c.ph == P_STEP) begin
      n.cyc = (c.cyc + 1 > MAXV) ? MAXV : c.cyc + 1;
      n.ret = (c.ret + rvi > MAXV) ? MAXV : c.ret + rvi;
      n.cause = -1;
      if (c.ph == P_RUN) begin
        if (c.rl != 0 && n.ret == c.rl)      n.cause = 2;
        else if (c.cl != 0 && n.cyc == c.cl) n.cause = 1;
        else if (hr)                         n.cause = 3;
      end else begin
        if (rv)      n.cause = 0;
        else if (hr) n.cause = 3;
      end
      if (n.cause < 0) n.cause = c.cause;
      else begin
        n.ph = P_HALT;
        n.dn = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= nxt(m, rst, start, step, halt_req, retire_valid, int'(cycle_limit), int'(retire_limit));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("core_rst_n", 32'(core_rst_n), 32'(!(m.ph == P_IDLE || m.ph == P_RST)));
      check("core_stall", 32'(core_stall), 32'(!(m.ph == P_RUN || m.ph == P_STEP)));
      check("busy", 32'(busy), 32'(m.ph == P_RST || m.ph == P_RUN || m.ph == P_STEP));
      check("done", 32'(done), 32'(m.dn));
      check("done_cause", 32'(done_cause), 32'(m.cause));
      check("cycle_count", 32'(cycle_count), 32'(m.cyc));
      check("instr_retired", 32'(instr_retired), 32'(m.ret));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int cl, input int rl);
    cycle_limit  = W'(cl);
    retire_limit = W'(rl);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL %s timeout: done not seen within %0d cycles", nm, maxc);
  endtask

  // Returns at the negedge of the first unstalled cycle, counting core_rst_n-low cycles.
  task automatic wait_run(input int maxc, input string nm, output int low_cnt);
    low_cnt = 0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (core_stall === 1'b0) return;
      if (core_rst_n === 1'b0) low_cnt++;
    end
    checks++;
    errors++;
    $display("FAIL %s timeout: run not entered within %0d cycles", nm, maxc);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_rst_n", 32'(core_rst_n), 32'd0);
    check("reset_stall", 32'(core_stall), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cyc", 32'(cycle_count), 32'd0);

    // Cycle limit 10 with a retirement every cycle.
    rv_mode = 1;
    launch(10, 0);
    wait_done(40, "t1");
    check("t1_cyc", 32'(cycle_count), 32'd10);
    check("t1_ret", 32'(instr_retired), 32'd10);
    check("t1_cause", 32'(done_cause), 32'd1);
    check("t1_busy_with_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_done_single", 32'(done), 32'd0);

    // Retire limit 5 with alternating retirements; relaunch from HALTED.
    rv_mode = 2;
    launch(100, 5);
    wait_run(10, "t2", lows);
    check("t2_rst_low_cycles", 32'(lows), 32'd2);
    wait_done(40, "t2");
    check("t2_ret", 32'(instr_retired), 32'd5);
    check("t2_cyc_9_or_10", 32'(cycle_count == 9 || cycle_count == 10), 32'd1);
    check("t2_cause", 32'(done_cause), 32'd2);

    // Both limits hit together: retire limit has priority.
    rv_mode = 1;
    launch(4, 4);
    wait_done(20, "t3");
    check("t3_cause", 32'(done_cause), 32'd2);
    check("t3_cyc", 32'(cycle_count), 32'd4);
    check("t3_ret", 32'(instr_retired), 32'd4);

    // halt_req in RUN cycle 7, then a single step retiring on its third cycle.
    rv_mode = 0;
    rv_man  = 1'b0;
    launch(0, 0);
    wait_run(10, "t4", lows);
    repeat (6) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_done(4, "t4_halt");
    check("t4_cyc", 32'(cycle_count), 32'd7);
    check("t4_cause", 32'(done_cause), 32'd3);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    rv_man = 1'b1;
    tick();
    rv_man = 1'b0;
    wait_done(4, "t4_step");
    check("t4_step_cyc", 32'(cycle_count), 32'd10);
    check("t4_step_ret", 32'(instr_retired), 32'd1);
    check("t4_step_cause", 32'(done_cause), 32'd0);

    // start and step together in HALTED: start wins.
    cycle_limit = W'(3);
    start = 1'b1;
    step  = 1'b1;
    tick();
    start = 1'b0;
    step  = 1'b0;
    @(negedge clk);
    check("both_start_wins", 32'(core_rst_n), 32'd0);
    wait_done(20, "both");
    check("both_cause", 32'(done_cause), 32'd1);
    check("both_cyc", 32'(cycle_count), 32'd3);

    // rst mid-RUN, then start pulses during RESET_CORE and RUN are ignored.
    rv_mode = 1;
    launch(0, 0);
    wait_run(10, "t5a", lows);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_n", 32'(core_rst_n), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cyc", 32'(cycle_count), 32'd0);
    launch(0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run(10, "t5b", lows);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("t5_start_ignored_cyc", 32'(cycle_count), 32'd4);
    check("t5_start_ignored_busy", 32'(busy), 32'd1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_done(4, "t5");
    check("t5_halt_cyc", 32'(cycle_count), 32'd5);
    launch(0, 0);
    @(negedge clk);
    check("t5_relaunch_clear", 32'(cycle_count), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Unlimited run long enough to saturate both counters.
    launch(0, 0);
    wait_run(10, "t6", lows);
    repeat (300) tick();
    @(negedge clk);
    check("t6_sat_cyc", 32'(cycle_count), 32'(MAXV));
    check("t6_sat_ret", 32'(instr_retired), 32'(MAXV));
    check("t6_no_halt", 32'(busy), 32'd1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_done(4, "t6");
    check("t6_cause", 32'(done_cause), 32'd3);

    // Random traffic against the model.
    rv_mode = 3;
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 15) == 0);
      step     = ($urandom_range(0, 7) == 0);
      halt_req = ($urandom_range(0, 24) == 0);
      rst      = ($urandom_range(0, 399) == 0);
      cycle_limit  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 40));
      retire_limit = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 30));
      tick();
    end
    start    = 1'b0;
    step     = 1'b0;
    halt_req = 1'b0;
    rst      = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
